// File: rtl/fpadd_issue_ctrl.sv
// Issue stage for the single-precision fpadd core: operand FIFO, one-op-in-flight
// sequencer with stale-done guard and watchdog abort, valid/ready result port.
module fpadd_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        fp_start,
  output logic [31:0] fp_a,
  output logic [31:0] fp_b,
  input  logic        fp_done,
  input  logic [31:0] fp_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_err,
  output logic        busy,
  output logic [2:0]  dbg_state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [7:0]    WD_LAST  = 8'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GUARD = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and a presented result stays stable until taken.

  logic [31:0]   mem_a_q [DEPTH];
  logic [31:0]   mem_b_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  state_t        state_q, state_d;
  logic [7:0]    wdog_q, wdog_d;
  logic          fp_start_q, fp_start_d;
  logic [31:0]   fp_a_q, fp_a_d, fp_b_q, fp_b_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_sum_q, out_sum_d;
  logic          out_err_q, out_err_d;
  logic          push, pop;

  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    fp_start_d  = 1'b0;
    fp_a_d      = fp_a_q;
    fp_b_d      = fp_b_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_err_d   = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          fp_a_d     = mem_a_q[rd_ptr_q];
          fp_b_d     = mem_b_q[rd_ptr_q];
          fp_start_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_GUARD;
      // fp_done may still be high from the previous op; it is only trusted from WAIT on.
      S_GUARD: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fp_done) begin
          out_sum_d   = fp_sum;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else if (wdog_q == WD_LAST) begin
          out_sum_d   = QNAN;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wdog_q      <= '0;
      fp_start_q  <= 1'b0;
      fp_a_q      <= '0;
      fp_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      fp_start_q  <= fp_start_d;
      fp_a_q      <= fp_a_d;
      fp_b_q      <= fp_b_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_err_q   <= out_err_d;
    end
  end

  assign fp_start    = fp_start_q;
  assign fp_a        = fp_a_q;
  assign fp_b        = fp_b_q;
  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_err     = out_err_q;
  assign busy        = (count_q != '0) || (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule
